// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour codes and the pattern-sequencer state type.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] BLUE  = 3'b001;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] CYAN  = 3'b011;
    localparam logic [2:0] RED   = 3'b100;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/vga_timing.sv
// Pixel/line counters with combinational active, sync, start-of-frame and end-of-frame decode.
module vga_timing #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic [9:0] o_h,
    output logic [9:0] o_v,
    output logic       o_active,
    output logic       o_hsync_n,
    output logic       o_vsync_n,
    output logic       o_sof,
    output logic       o_eof
);

    localparam logic [9:0] LP_H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] LP_H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] LP_HS_LO  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] LP_HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] LP_V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] LP_V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] LP_VS_LO  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] LP_VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] r_h;
    logic [9:0] r_v;
    logic       w_h_last;
    logic       w_v_last;

    assign w_h_last = (r_h == LP_H_LAST);
    assign w_v_last = (r_v == LP_V_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? '0 : r_v + 10'd1;
        end else begin
            r_h <= r_h + 10'd1;
        end
    end

    assign o_h       = r_h;
    assign o_v       = r_v;
    assign o_active  = (r_h < LP_H_ACT) && (r_v < LP_V_ACT);
    assign o_hsync_n = !((r_h >= LP_HS_LO) && (r_h <= LP_HS_HI));
    assign o_vsync_n = !((r_v >= LP_VS_LO) && (r_v <= LP_VS_HI));
    assign o_sof     = (r_h == 10'd0) && (r_v == 10'd0);
    assign o_eof     = w_h_last && w_v_last;

endmodule

// File: rtl/vga_pattern_ctrl.sv
// Test-pattern sequencer: frame-boundary pattern switching (manual/auto) and registered, blanked output.
module vga_pattern_ctrl #(
    parameter int H_ACTIVE           = vga_pkg::H_ACTIVE,
    parameter int H_FP               = vga_pkg::H_FP,
    parameter int H_SYNC             = vga_pkg::H_SYNC,
    parameter int H_BP               = vga_pkg::H_BP,
    parameter int V_ACTIVE           = vga_pkg::V_ACTIVE,
    parameter int V_FP               = vga_pkg::V_FP,
    parameter int V_SYNC             = vga_pkg::V_SYNC,
    parameter int V_BP               = vga_pkg::V_BP,
    parameter int NUM_PATTERNS       = 4,
    parameter int FRAMES_PER_PATTERN = 60
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      next_i,
    input  logic                      auto_en_i,
    input  logic [3*NUM_PATTERNS-1:0] pat_rgb_i,
    output logic [9:0]                column_o,
    output logic [9:0]                row_o,
    output logic [1:0]                pattern_sel_o,
    output logic [2:0]                rgb_o,
    output logic                      hsync_o,
    output logic                      vsync_o,
    output logic                      video_on_o,
    output logic                      frame_start_o
);
    import vga_pkg::*;

    localparam int              FC_W     = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FRAMES_PER_PATTERN - 1);
    localparam logic [1:0]      SEL_LAST = 2'(NUM_PATTERNS - 1);

    logic            w_active, w_hsync_n, w_vsync_n, w_sof, w_eof;
    ctrl_state_e     r_state, w_state_next;
    logic [1:0]      r_sel, w_sel_next;
    logic [FC_W-1:0] r_fcnt, w_fcnt_next;
    logic            w_advance;
    logic [2:0]      w_pix;
    logic [2:0]      r_rgb;
    logic            r_hsync_n, r_vsync_n, r_video_on, r_frame_start;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .i_clk     (clk_i),
        .i_rst_n   (rst_ni),
        .o_h       (column_o),
        .o_v       (row_o),
        .o_active  (w_active),
        .o_hsync_n (w_hsync_n),
        .o_vsync_n (w_vsync_n),
        .o_sof     (w_sof),
        .o_eof     (w_eof)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_fcnt_next  = r_fcnt;
        w_advance    = 1'b0;
        if (w_eof) begin
            // A pending request, a request on the EOF cycle itself and an auto expiry merge into one step.
            w_advance    = (r_state == PEND) || next_i || (auto_en_i && (r_fcnt == FC_LAST));
            w_state_next = RUN;
            if (w_advance) begin
                w_sel_next  = (r_sel == SEL_LAST) ? 2'd0 : r_sel + 2'd1;
                w_fcnt_next = '0;
            end else if (auto_en_i) begin
                w_fcnt_next = r_fcnt + FC_W'(1);
            end
        end else if (next_i) begin
            w_state_next = PEND;
        end
        if (!auto_en_i) begin
            w_fcnt_next = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= RUN;
            r_sel   <= '0;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
            r_fcnt  <= w_fcnt_next;
        end
    end

    always_comb begin
        w_pix = BLACK;
        for (int k = 0; k < NUM_PATTERNS; k++) begin
            if (r_sel == 2'(k)) begin
                w_pix = pat_rgb_i[3*k +: 3];
            end
        end
    end

    // Sync and flag terms share the pre-edge counters with the pixel, so they stay aligned to rgb_o.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rgb         <= BLACK;
            r_hsync_n     <= 1'b1;
            r_vsync_n     <= 1'b1;
            r_video_on    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_rgb         <= w_active ? w_pix : BLACK;
            r_hsync_n     <= w_hsync_n;
            r_vsync_n     <= w_vsync_n;
            r_video_on    <= w_active;
            r_frame_start <= w_sof;
        end
    end

    assign pattern_sel_o = r_sel;
    assign rgb_o         = r_rgb;
    assign hsync_o       = r_hsync_n;
    assign vsync_o       = r_vsync_n;
    assign video_on_o    = r_video_on;
    assign frame_start_o = r_frame_start;

endmodule

// File: doc/vga_pattern_ctrl.md
Name: vga_pattern_ctrl

Overview:
- Sequencer for the 640x480@60 Hz VGA test-pattern datapath.
- Generates the pixel timing (column/row counters, hsync, vsync) that drives the combinational pattern generators.
- Selects one of NUM_PATTERNS generator outputs, switching only at frame boundaries (no tearing), on a manual request or automatically every FRAMES_PER_PATTERN frames.
- Outputs registered, blanked RGB plus syncs aligned to it.

Parameters:
- H_ACTIVE, 640, visible columns
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch (H_TOTAL = 800)
- V_ACTIVE, 480, visible rows
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch (V_TOTAL = 525)
- NUM_PATTERNS, 4, number of generator inputs, 2..4
- FRAMES_PER_PATTERN, 60, frames per pattern in auto mode, >= 1

Ports:
- clk_i  in  1  25 MHz pixel clock
- rst_ni  in  1  synchronous, active-low reset
- next_i  in  1  manual advance request, level or pulse, sampled every cycle
- auto_en_i  in  1  1 = auto advance enabled
- pat_rgb_i  in  3*NUM_PATTERNS  generator outputs; pattern k at bits [3k+2:3k]
- column_o  out  10  horizontal counter, 0..H_TOTAL-1, to generators
- row_o  out  10  vertical counter, 0..V_TOTAL-1, to generators
- pattern_sel_o  out  2  active pattern index
- rgb_o  out  3  registered pixel colour, 0 when blanked
- hsync_o  out  1  active-low hsync, aligned to rgb_o
- vsync_o  out  1  active-low vsync, aligned to rgb_o
- video_on_o  out  1  1 when rgb_o is a visible pixel
- frame_start_o  out  1  one-cycle pulse aligned to rgb_o of pixel (0,0)

Behaviour:
- Reset (rst_ni=0 at a rising edge): h=v=0, pattern_sel_o=0, frame counter=0, FSM=RUN, rgb_o=0, video_on_o=0, hsync_o=1, vsync_o=1, frame_start_o=0. Reset mid-frame restarts the frame at (0,0) on the next edge.
- Counters:
  - h increments every cycle and wraps H_TOTAL-1 -> 0.
  - v increments when h wraps and wraps V_TOTAL-1 -> 0.
  - column_o and row_o are the counter registers directly (no logic after the flops).
- Pipeline, latency 1:
  - At each edge, rgb_o <= (h<H_ACTIVE && v<V_ACTIVE) ? pat_rgb_i[pattern_sel_o] : 0.
  - hsync_o <= !(h in [656,751]); vsync_o <= !(v in [490,491]).
  - video_on_o <= active; frame_start_o <= (h==0 && v==0).
  - All terms are evaluated on the same pre-edge (h, v), so they stay mutually aligned.
- EOF is the cycle with h==H_TOTAL-1 && v==V_TOTAL-1. pattern_sel_o and the frame counter change only at the EOF edge.
- FSM, states RUN and PEND:
  - RUN -> PEND when next_i=1 in a non-EOF cycle.
  - PEND stays PEND on further next_i; requests are not queued, so at most one manual advance per frame.
  - At the EOF edge, advance if (state==PEND || next_i==1) || (auto_en_i && frame_cnt==FRAMES_PER_PATTERN-1). State returns to RUN.
  - A manual request and an auto expiry at the same EOF give one advance, not two.
- Advance: pattern_sel_o <= (sel==NUM_PATTERNS-1) ? 0 : sel+1, and the frame counter clears to 0.
- Frame counter:
  - Width is clog2(FRAMES_PER_PATTERN).
  - If no advance occurs, it increments at the EOF edge when auto_en_i=1.
  - It is forced to 0 whenever auto_en_i=0, so re-enabling auto mode gives a full FRAMES_PER_PATTERN interval.
- pat_rgb_i is treated as combinational from column_o/row_o within the same cycle.

Decomposition:
- Package vga_pkg holds:
  - the timing localparams (H_*/V_* and derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END);
  - colour constants BLACK=000, BLUE=001, GREEN=010, CYAN=011, RED=100;
  - the FSM state enum (RUN, PEND).
- One sub-module, vga_timing: h/v counters, active/sync decode and EOF flag.
- vga_pattern_ctrl holds the FSM, frame counter, select mux and output registers.

Test Plan:
- Hold rst_ni=0 for 5 cycles, release -> 1 cycle later frame_start_o=1, video_on_o=1, rgb_o=pattern0 at (0,0); during reset hsync_o=vsync_o=1 and rgb_o=0.
- Free run one line -> hsync_o=0 for exactly 96 cycles, first low output for h=656; video_on_o high 640 cycles per line; rgb_o=0 for h>=640; line period 800.
- Free run one frame -> vsync_o=0 for exactly 2 lines (v=490,491); frame period 420000 cycles; frame_start_o once per frame.
- auto_en_i=0, pulse next_i at (h=100, v=200), then again at v=300 -> pattern_sel_o goes 0->1 only at the EOF edge (one advance); all rows of that frame use pattern 0.
- FRAMES_PER_PATTERN=2, NUM_PATTERNS=4, auto_en_i=1 -> sel sequence 0,1,2,3,0, changing every 2 frames. next_i at EOF of an auto-expiry frame -> single increment.
- Drop rst_ni mid-frame (h=300, v=100) with sel=2 and PEND set -> on the next edge h=v=0, sel=0, FSM=RUN, frame counter=0; the next frame starts cleanly.
